// File: rtl/red_pitaya_sh_gate.sv
// Sample-and-hold gate ahead of the S&H PID: hysteretic, debounced trigger
// qualification, held process value, post-release settle blanking, hold event count.
module red_pitaya_sh_gate #(
  parameter int unsigned DW      = 14,
  parameter int unsigned DEB_LEN = 4,
  parameter int unsigned CW      = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic signed [DW-1:0] dat_i,
  input  logic signed [DW-1:0] trig_i,
  input  logic signed [DW-1:0] thr_hi_i,
  input  logic signed [DW-1:0] thr_lo_i,
  input  logic        [7:0]    settle_i,
  input  logic                 cnt_clr_i,
  output logic signed [DW-1:0] dat_o,
  output logic                 hold_o,
  output logic                 run_o,
  output logic        [CW-1:0] hold_cnt_o
);

  localparam int unsigned DBW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
  localparam logic [DBW-1:0] DEB_LAST = DBW'(DEB_LEN - 1);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_RUN    = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t                r_state;
  logic        [7:0]     r_settle_cnt;
  logic        [DBW-1:0] r_deb_cnt;
  logic signed [DW-1:0]  r_dat;
  logic                  r_hold;
  logic                  r_run;
  logic        [CW-1:0]  r_hold_cnt;

  logic signed [DW-1:0]  w_thr_lo_eff;
  logic                  w_qual;
  logic                  w_rel;
  logic                  w_deb_hit;
  logic                  w_enter;

  // An inverted window collapses to zero hysteresis at thr_hi
  assign w_thr_lo_eff = (thr_lo_i > thr_hi_i) ? thr_hi_i : thr_lo_i;
  assign w_qual       = (trig_i >= thr_hi_i);
  assign w_rel        = (trig_i < w_thr_lo_eff);
  assign w_deb_hit    = w_qual && (r_deb_cnt == DEB_LAST);
  assign w_enter      = (r_state != ST_HOLD) && w_deb_hit;

  // Gate state machine with state-aligned hold/run flags
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= ST_SETTLE;
      r_settle_cnt <= 8'd0;
      r_deb_cnt    <= '0;
      r_dat        <= '0;
      r_hold       <= 1'b0;
      r_run        <= 1'b0;
    end else begin
      case (r_state)
        ST_SETTLE, ST_RUN: begin
          r_dat <= dat_i;
          if (w_deb_hit) begin
            r_state   <= ST_HOLD;
            r_hold    <= 1'b1;
            r_run     <= 1'b0;
            r_deb_cnt <= '0;
          end else begin
            r_deb_cnt <= w_qual ? (r_deb_cnt + DBW'(1)) : '0;
            if (r_state == ST_SETTLE) begin
              if (r_settle_cnt == settle_i) begin
                r_state <= ST_RUN;
                r_run   <= 1'b1;
              end else begin
                r_settle_cnt <= r_settle_cnt + 8'd1;
              end
            end
          end
        end
        ST_HOLD: begin
          r_deb_cnt <= '0;
          if (w_rel) begin
            r_state      <= ST_SETTLE;
            r_settle_cnt <= 8'd0;
            r_hold       <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_SETTLE;
          r_settle_cnt <= 8'd0;
          r_deb_cnt    <= '0;
          r_hold       <= 1'b0;
          r_run        <= 1'b0;
        end
      endcase
    end
  end

  // Saturating hold-entry counter; an entry wins over a coincident clear
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_hold_cnt <= '0;
    end else if (w_enter) begin
      if (cnt_clr_i) begin
        r_hold_cnt <= CW'(1);
      end else if (!(&r_hold_cnt)) begin
        r_hold_cnt <= r_hold_cnt + CW'(1);
      end
    end else if (cnt_clr_i) begin
      r_hold_cnt <= '0;
    end
  end

  assign dat_o      = r_dat;
  assign hold_o     = r_hold;
  assign run_o      = r_run;
  assign hold_cnt_o = r_hold_cnt;

endmodule
